itcm_loader: RTL

ITCM_LOADER -- requirements
Module: itcm_loader

---
 rtl/itcm_loader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/itcm_loader.sv
// itcm_loader: assembles a little-endian byte stream into 32-bit words and
// writes them into an ITCM window through single, non-pipelined AHB-Lite
// NONSEQ write transfers.
module itcm_loader #(
    parameter int          AW        = 15,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          sys_root_clk,
    input  logic          sys_root_rst,
    input  logic          start,
    input  logic [AW-2:0] len_words,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic [31:0]   haddr,
    output logic [1:0]    htrans,
    output logic [2:0]    hsize,
    output logic          hwrite,
    output logic [3:0]    hprot,
    output logic [31:0]   hwdata,
    input  logic          hready,
    input  logic          hresp,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-2:0] words_written
);

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ADDR, S_DATA, S_ERR} state_t;

    state_t        state, state_nxt;
    logic [AW-2:0] len_q;
    logic [AW-3:0] offset;
    logic [1:0]    lane;
    logic [31:0]   word_q;
    logic          abort_pend;

    logic          start_ok, byte_ok, data_err, data_ok, last_word, stop_req;
    logic [AW-2:0] ww_inc;
    logic [AW-1:0] addr_lo;

    // Abort beats a coincident start in IDLE.
    assign start_ok  = (state == S_IDLE) && start && !abort;
    assign byte_ok   = s_ready && s_valid;
    assign data_err  = (state == S_DATA) && hresp;
    assign data_ok   = (state == S_DATA) && hready && !hresp;
    assign ww_inc    = words_written + 1'b1;
    assign last_word = (ww_inc == len_q);
    // An abort seen during ADDR is remembered so the transfer can finish first.
    assign stop_req  = abort || abort_pend;
    // Offset wraps naturally inside the window; upper address bits come from BASE_ADDR.
    assign addr_lo   = BASE_ADDR[AW-1:0] + {offset, 2'b00};

    assign hsize  = 3'b010;
    assign hprot  = 4'b0011;
    assign hwdata = word_q;

    // State register.
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok && (len_words != '0)) state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (abort)                          state_nxt = S_IDLE;
                else if (byte_ok && lane == 2'd3)   state_nxt = S_ADDR;
            end
            S_ADDR: begin
                htrans = 2'b10;
                hwrite = 1'b1;
                busy   = 1'b1;
                if (hready) state_nxt = S_DATA;
            end
            S_DATA: begin
                busy = 1'b1;
                if (hresp)       state_nxt = S_ERR;
                else if (hready) state_nxt = (last_word || stop_req) ? S_IDLE : S_COLLECT;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load setup, byte assembly, address latch, completion bookkeeping.
    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            len_q         <= '0;
            offset        <= '0;
            lane          <= 2'd0;
            word_q        <= 32'h0;
            abort_pend    <= 1'b0;
            haddr         <= BASE_ADDR;
            done          <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q         <= len_words;
                        offset        <= '0;
                        lane          <= 2'd0;
                        err           <= 1'b0;
                        words_written <= '0;
                        abort_pend    <= 1'b0;
                        if (len_words == '0) done <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (!abort && byte_ok) begin
                        word_q[8*lane +: 8] <= s_data;
                        lane                <= lane + 2'd1;
                        // haddr is latched once per word and then held until the next one.
                        if (lane == 2'd3) haddr <= {BASE_ADDR[31:AW], addr_lo};
                    end
                end
                S_ADDR: begin
                    if (abort) abort_pend <= 1'b1;
                end
                S_DATA: begin
                    if (abort) abort_pend <= 1'b1;
                    if (data_err) begin
                        err <= 1'b1;
                    end else if (data_ok) begin
                        words_written <= ww_inc;
                        offset        <= offset + 1'b1;
                        if (last_word && !stop_req) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
